instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage between the 8-bit byte memory and the control unit decode.
//  Reads two bytes per instruction: low byte at PC, high byte at PC+1.
//  Presents a 16-bit instruction with a valid/ready handshake.
//  Accepts a redirect (jump target) from the control unit, which flushes the fetch in progress.
// PARAMETERS
//  RESET_PC   16'h0000  PC loaded on reset
//  PC_STEP    2         PC increment per fetched instruction (bytes)
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   asynchronous reset, active-low
//  mem_req         out  1   fetch drives mem_addr this cycle (read only, rw=0)
//  mem_gnt         in   1   bus granted to fetch this cycle
//  mem_addr        out  16  byte address to memory
//  mem_q           in   8   read data, valid 1 cycle after the address is granted
//  instr           out  16  fetched instruction {hi,lo}
//  instr_pc        out  16  address of instr's low byte
//  instr_valid     out  1   instr/instr_pc valid
//  instr_ready     in   1   decode accepts instr this cycle
//  redirect_valid  in   1   load new PC, flush pending fetch
//  redirect_addr   in   16  new PC
// BEHAVIOUR
//  Reset (rst=0, async):
//   - pc=RESET_PC, state=S_LO.
//   - instr=0, instr_pc=0, instr_valid=0, mem_req=0, mem_addr=0.
//  States:
//   - S_LO: mem_req=1, mem_addr=pc. gnt=1 -> S_HI, else stay.
//   - S_HI: mem_req=1, mem_addr=pc+1 (16-bit wrap). lo<=mem_q if previous cycle was a granted S_LO.
//     gnt=1 -> S_CAP, else stay (lo held).
//   - S_CAP: mem_req=0; instr<={mem_q,lo}, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP.
//     -> S_HOLD.
//   - S_HOLD: instr_valid=1. instr_ready=1 -> instr_valid<=0, -> S_LO.
//  Timing: min latency S_LO -> instr_valid = 3 cycles. One instruction per 4 cycles sustained.
//  Handshake:
//   - A transfer occurs on a rising edge with instr_valid & instr_ready.
//   - instr and instr_pc are stable while valid & !ready.
//  Redirect (highest priority, any state):
//   - pc<=redirect_addr, state<=S_LO, instr_valid<=0, in-flight byte discarded.
//   - If instr_ready is high in the same cycle, that transfer still counts as consumed.
//  Arithmetic: all PC math is modulo 2^16. 16'hFFFF+1 -> 16'h0000.
//   - Odd addresses are legal; no alignment check.
//  mem_gnt low in S_CAP/S_HOLD is ignored (no bus use).
//  Reset asserted mid-fetch: all state cleared immediately; no partial instr emitted.
// CONFIGURATION
//  FETCH_PREFETCH_EN defined:
//   - Adds a 1-entry prefetch register.
//   - In S_HOLD with valid & !ready, fetch of the next instruction proceeds into the prefetch entry.
//   - On ready, prefetch moves to instr the next cycle (valid stays 1); back-to-back throughput
//     is 1 instr per 3 cycles.
//   - Redirect flushes both entries.
//   - Fetch stalls in S_LO when both entries are full.
//  Undefined:
//   - No prefetch; at most one instruction buffered.
//   - Fetch idles while instr_valid=1.
// TESTING
//  1. Reset, mem[0]=8'h34, mem[1]=8'h12, gnt=1, ready=1
//     -> instr=16'h1234, instr_pc=0 at cycle 3, then instr_pc=2.
//  2. ready=0 for 10 cycles after valid
//     -> instr held, mem_req=0 (no macro), no pc change. Then ready=1 -> next fetch starts.
//  3. gnt=0 for 5 cycles in S_HI
//     -> mem_addr stays pc+1, lo byte preserved, correct instr once gnt returns.
//  4. redirect to 16'h0100 during S_HI
//     -> no instr from old pc. Next valid instr_pc=16'h0100.
//     Redirect together with valid&ready -> one transfer only.
//  5. pc=16'hFFFF
//     -> lo from FFFF, hi from 0000, instr_pc=FFFF, next pc=16'h0001.
//  6. FETCH_PREFETCH_EN, ready=1 continuous
//     -> valid instrs every 3 cycles. Redirect clears both entries.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit instructions as two bytes from 8-bit memory.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_q,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr
);

  typedef enum logic [1:0] {
    S_LO, S_HI, S_CAP, S_HOLD
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [7:0]  lo;
  logic        lo_pend;
  logic        gnt;
  logic        consume;
  logic        cap;
  logic        stall;
  logic [15:0] cap_word;

  assign gnt      = mem_req & mem_gnt;
  assign consume  = instr_valid & instr_ready;
  assign cap      = (state == S_CAP) & ~redirect_valid;
  assign cap_word = {mem_q, lo};
  assign pc_nxt   = pc + 16'(PC_STEP);

`ifdef FETCH_PREFETCH_EN
  logic [15:0] pf_instr;
  logic [15:0] pf_pc;
  logic        pf_valid;
  logic        v_nxt;
  logic        p_nxt;

  // Occupancy of both entries after this edge; fetch waits when both fill.
  assign v_nxt = cap | (consume ? pf_valid : instr_valid);
  assign p_nxt = cap ? (instr_valid & (~consume | pf_valid))
                     : (pf_valid & ~consume);
  assign stall = v_nxt & p_nxt;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_LO;
      pc       <= RESET_PC;
      lo       <= '0;
      lo_pend  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (redirect_valid) begin
      state    <= S_LO;
      pc       <= redirect_addr;
      lo_pend  <= 1'b0;
      mem_req  <= 1'b1;
      mem_addr <= redirect_addr;
    end else begin
      unique case (state)
        S_LO: begin
          if (gnt) begin
            state    <= S_HI;
            lo_pend  <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= pc + 16'd1;
          end else begin
            mem_req  <= ~stall;
            mem_addr <= pc;
          end
        end
        S_HI: begin
          if (lo_pend) begin
            lo      <= mem_q;
            lo_pend <= 1'b0;
          end
          if (gnt) begin
            state   <= S_CAP;
            mem_req <= 1'b0;
          end
        end
        S_CAP: begin
          pc <= pc_nxt;
`ifdef FETCH_PREFETCH_EN
          state    <= S_LO;
          mem_req  <= ~stall;
          mem_addr <= pc_nxt;
`else
          state    <= S_HOLD;
`endif
        end
        S_HOLD: begin
          if (consume) begin
            state    <= S_LO;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      pf_instr    <= '0;
      pf_pc       <= '0;
      pf_valid    <= 1'b0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      pf_valid    <= 1'b0;
    end else if (cap) begin
      if (!instr_valid || (consume && !pf_valid)) begin
        instr       <= cap_word;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (consume) begin
        instr    <= pf_instr;
        instr_pc <= pf_pc;
        pf_instr <= cap_word;
        pf_pc    <= pc;
      end else begin
        pf_instr <= cap_word;
        pf_pc    <= pc;
        pf_valid <= 1'b1;
      end
    end else if (consume) begin
      if (pf_valid) begin
        instr    <= pf_instr;
        instr_pc <= pf_pc;
        pf_valid <= 1'b0;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
    end else if (cap) begin
      instr       <= cap_word;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table plus scoreboard of expected transfers.
// Byte memory model answers one cycle after a granted request.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic        mem_gnt = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_q = 8'h00;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_gnt       (mem_gnt),
    .mem_addr      (mem_addr),
    .mem_q         (mem_q),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr)
  );

  logic [7:0] mem [0:65535];

  always @(posedge clk)
    if (mem_req && mem_gnt) mem_q <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic [15:0] pc;
    int          lo_stall;
    int          hi_stall;
    int          rdy_delay;
    bit          follow;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc;
  } vec_t;

  exp_t sb[$];
  vec_t vt[6];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_xfer = 0;
  int   last_xfer_cyc = 0;
  int   xfer_gap = 0;

  function automatic exp_t model(input logic [15:0] a);
    logic [15:0] b;
    exp_t e;
    b = a + 16'd1;
    e.instr = {mem[b], mem[a]};
    e.pc = a;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer_check();
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL xfer_unexpected: got instr %h pc %h expected none",
               instr, instr_pc);
    end else begin
      e = sb.pop_front();
      if (instr !== e.instr || instr_pc !== e.pc) begin
        n_fail++;
        $display("FAIL xfer_data: got %h@%h expected %h@%h",
                 instr, instr_pc, e.instr, e.pc);
      end
    end
    xfer_gap = cyc - last_xfer_cyc;
    last_xfer_cyc = cyc;
    n_xfer++;
  endtask

  // Transfers are observed at the falling edge before the rising edge
  // that completes them.
  task automatic tick();
    @(negedge clk);
    if (rst && instr_valid && instr_ready) xfer_check();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (n_xfer < target && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 32'(n_xfer), 32'(target));
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int k;
    k = 0;
    while (!instr_valid && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 32'(instr_valid), 32'd1);
  endtask

  task automatic flush_to(input logic [15:0] a);
    redirect_valid = 1'b1;
    redirect_addr = a;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
  endtask

  initial begin
    int c0;
    int n0;
    logic [15:0] h;
    for (int i = 0; i < 65536; i++)
      mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
    mem[0] = 8'h34;
    mem[1] = 8'h12;

    vt[0] = '{16'h0100, 0, 0, 0, 1'b1, 16'h0, 16'h0};
    vt[1] = '{16'h0055, 2, 5, 3, 1'b0, 16'h0, 16'h0};
    vt[2] = '{16'hFFFF, 0, 0, 0, 1'b1, 16'h0, 16'h0};
    vt[3] = '{16'hFFFE, 1, 1, 1, 1'b1, 16'h0, 16'h0};
    vt[4] = '{16'h8001, 0, 3, 0, 1'b0, 16'h0, 16'h0};
    vt[5] = '{16'h1230, 3, 0, 10, 1'b0, 16'h0, 16'h0};
    for (int i = 0; i < 6; i++) begin
      vt[i].exp_instr = model(vt[i].pc).instr;
      vt[i].exp_pc = vt[i].pc;
    end

    // reset state
    repeat (2) tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);

    // first fetch latency and back-to-back with ready high
    instr_ready = 1'b1;
    sb.push_back(model(16'h0000));
    sb.push_back(model(16'h0002));
    rst = 1'b1;
    c0 = 0;
    for (int k = 0; k < 10 && !mem_req; k++) tick();
    chk("t1_req", 32'(mem_req), 32'd1);
    c0 = cyc;
    wait_valid(10, "t1_valid");
    chk("t1_latency", 32'(cyc - c0), 32'd3);
    chk("t1_instr", 32'(instr), 32'h1234);
    chk("t1_pc", 32'(instr_pc), 32'h0000);
    wait_n(2, 20, "t1_xfers");
    instr_ready = 1'b0;

    // hold with ready low
    sb.push_back(model(16'h0004));
    wait_valid(10, "t2_valid");
    h = instr;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2_hold_instr", 32'(instr), 32'(h));
      chk("t2_hold_pc", 32'(instr_pc), 32'h0004);
      chk("t2_hold_valid", 32'(instr_valid), 32'd1);
`ifndef FETCH_PREFETCH_EN
      chk("t2_hold_req", 32'(mem_req), 32'd0);
`endif
    end
    sb.push_back(model(16'h0006));
    instr_ready = 1'b1;
    wait_n(4, 20, "t2_xfers");
    instr_ready = 1'b0;

    // vector table: grant stalls, odd addresses, wrap
    foreach (vt[i]) begin
      mem_gnt = 1'b0;
      flush_to(vt[i].pc);
      sb.push_back('{vt[i].exp_instr, vt[i].exp_pc});
      n0 = n_xfer;
      for (int k = 0; k < vt[i].lo_stall; k++) begin
        chk("v_lo_addr", 32'(mem_addr), 32'(vt[i].pc));
        tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      for (int k = 0; k < vt[i].hi_stall; k++) begin
        chk("v_hi_addr", 32'(mem_addr), 32'(vt[i].pc + 16'd1));
        chk("v_hi_req", 32'(mem_req), 32'd1);
        tick();
      end
      mem_gnt = 1'b1;
      for (int k = 0; k < vt[i].rdy_delay; k++) tick();
      instr_ready = 1'b1;
      wait_n(n0 + 1, 30, "v_xfer");
      if (vt[i].follow) begin
        sb.push_back(model(vt[i].pc + 16'd2));
        wait_n(n0 + 2, 30, "v_follow");
      end
      instr_ready = 1'b0;
    end

    // redirect while the high byte is pending
    flush_to(16'h0200);
    tick();
    n0 = n_xfer;
    flush_to(16'h0100);
    sb.push_back(model(16'h0100));
    instr_ready = 1'b1;
    wait_n(n0 + 1, 20, "t4_xfer");
    chk("t4_pc", 32'(instr_pc), 32'h0100);
    instr_ready = 1'b0;

    // redirect in the same cycle as a transfer
    flush_to(16'h0300);
    sb.push_back(model(16'h0300));
    wait_valid(20, "t4b_valid");
    n0 = n_xfer;
    redirect_valid = 1'b1;
    redirect_addr = 16'h0400;
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    chk("t4b_one", 32'(n_xfer), 32'(n0 + 1));
    chk("t4b_flushed", 32'(instr_valid), 32'd0);
    sb.push_back(model(16'h0400));
    instr_ready = 1'b1;
    wait_n(n0 + 2, 20, "t4b_next");
    instr_ready = 1'b0;

`ifdef FETCH_PREFETCH_EN
    // prefetch throughput and flush of both entries
    flush_to(16'h0500);
    for (int k = 0; k < 4; k++)
      sb.push_back(model(16'h0500 + 16'(2 * k)));
    n0 = n_xfer;
    instr_ready = 1'b1;
    wait_n(n0 + 1, 20, "t6_first");
    for (int k = 2; k <= 4; k++) begin
      wait_n(n0 + k, 20, "t6_xfer");
      chk("t6_gap", 32'(xfer_gap), 32'd3);
    end
    instr_ready = 1'b0;
    repeat (12) tick();
    chk("t6_full", 32'(instr_valid), 32'd1);
    flush_to(16'h0700);
    chk("t6_flushed", 32'(instr_valid), 32'd0);
    sb.push_back(model(16'h0700));
    n0 = n_xfer;
    instr_ready = 1'b1;
    wait_n(n0 + 1, 20, "t6_after");
    instr_ready = 1'b0;
`endif

    // reset asserted mid-fetch
    flush_to(16'h0600);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    chk("mr_instr", 32'(instr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    sb.push_back(model(16'h0000));
    n0 = n_xfer;
    instr_ready = 1'b1;
    wait_n(n0 + 1, 20, "mr_xfer");
    instr_ready = 1'b0;
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
